// File: rtl/sram_pkg.sv
// Shared types and constants for the three-port SRAM arbiter.
// Holds the FSM encoding, port count, timeout counter width and the round-robin step helper.
package sram_pkg;

    localparam int NPORTS = 3;
    localparam int TCNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Next port in round-robin order; an out-of-range index restarts at port 0.
    function automatic logic [1:0] next_port(input logic [1:0] i_port);
        logic [1:0] r_next;
        r_next = (i_port >= 2'd2) ? 2'd0 : i_port + 2'd1;
        return r_next;
    endfunction

endpackage

// File: rtl/rr_select3.sv
// Combinational round-robin picker for three requesters.
// The search begins one past the most recent grant and wraps around.
module rr_select3
    import sram_pkg::*;
(
    input  logic [2:0] i_request,
    input  logic [1:0] i_last,
    output logic       o_valid,
    output logic [1:0] o_grant
);

    logic [1:0] w_first;
    logic [1:0] w_second;
    logic [1:0] w_third;

    assign w_first  = next_port(i_last);
    assign w_second = next_port(w_first);
    assign w_third  = next_port(w_second);
    assign o_valid  = |i_request;

    always_comb begin
        o_grant = w_first;
        if (i_request[w_first]) begin
            o_grant = w_first;
        end else if (i_request[w_second]) begin
            o_grant = w_second;
        end else if (i_request[w_third]) begin
            o_grant = w_third;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port round-robin arbiter in front of a single-request SRAM interface,
// with a BUSY-cycle timeout that aborts a stalled access.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no transaction; arbitrate the pending requests each cycle
// ST_BUSY    | o_sram_request high, waiting for i_sram_ready or timeout
// ST_RELEASE | one-cycle gap; o_pN_ready pulses for the granted port
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int TIMEOUT = 63
) (
    input  logic        i_clock,
    input  logic        i_reset_n,

    input  logic        i_p0_request,
    input  logic        i_p0_rw,
    input  logic [31:0] i_p0_address,
    input  logic [31:0] i_p0_wdata,
    output logic [31:0] o_p0_rdata,
    output logic        o_p0_ready,

    input  logic        i_p1_request,
    input  logic        i_p1_rw,
    input  logic [31:0] i_p1_address,
    input  logic [31:0] i_p1_wdata,
    output logic [31:0] o_p1_rdata,
    output logic        o_p1_ready,

    input  logic        i_p2_request,
    input  logic        i_p2_rw,
    input  logic [31:0] i_p2_address,
    input  logic [31:0] i_p2_wdata,
    output logic [31:0] o_p2_rdata,
    output logic        o_p2_ready,

    output logic        o_sram_request,
    output logic        o_sram_rw,
    output logic [31:0] o_sram_address,
    output logic [31:0] o_sram_wdata,
    input  logic [31:0] i_sram_rdata,
    input  logic        i_sram_ready,

    output logic        o_busy,
    output logic        o_error
);

    localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_last;
    logic [1:0]          r_grant;
    logic                r_sram_request;
    logic                r_sram_rw;
    logic [31:0]         r_sram_address;
    logic [31:0]         r_sram_wdata;
    logic [31:0]         r_rdata [NPORTS];
    logic [NPORTS-1:0]   r_ready;
    logic                r_error;
    logic [TCNT_W-1:0]   r_count;

    logic [2:0]          w_request;
    logic                w_valid;
    logic [1:0]          w_grant;
    logic                w_grant_en;
    logic                w_capture;
    logic                w_abort;
    logic                w_sel_rw;
    logic [31:0]         w_sel_address;
    logic [31:0]         w_sel_wdata;

    assign w_request = {i_p2_request, i_p1_request, i_p0_request};

    rr_select3 u_rr_select3 (
        .i_request (w_request),
        .i_last    (r_last),
        .o_valid   (w_valid),
        .o_grant   (w_grant)
    );

    always_comb begin
        w_sel_rw      = i_p0_rw;
        w_sel_address = i_p0_address;
        w_sel_wdata   = i_p0_wdata;
        case (w_grant)
            2'd1: begin
                w_sel_rw      = i_p1_rw;
                w_sel_address = i_p1_address;
                w_sel_wdata   = i_p1_wdata;
            end
            2'd2: begin
                w_sel_rw      = i_p2_rw;
                w_sel_address = i_p2_address;
                w_sel_wdata   = i_p2_wdata;
            end
            default: ;
        endcase
    end

    // Completion is checked before the timeout so a coinciding ready wins.
    always_comb begin
        w_state_next = r_state;
        w_grant_en   = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_grant_en   = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_sram_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RELEASE;
                end else if (r_count >= TIMEOUT_LAST) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last         <= 2'd2;
            r_grant        <= 2'd0;
            r_sram_request <= 1'b0;
            r_sram_rw      <= 1'b0;
            r_sram_address <= '0;
            r_sram_wdata   <= '0;
            r_ready        <= '0;
            r_error        <= 1'b0;
            r_count        <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                r_rdata[i] <= '0;
            end
        end else begin
            r_error <= w_abort;
            r_ready <= (w_capture || w_abort) ? (3'b001 << r_grant) : 3'b000;

            // Counter sits at zero outside BUSY, so every BUSY entry starts from zero.
            if (r_state == ST_BUSY) begin
                r_count <= r_count + {{(TCNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_count <= '0;
            end

            if (w_grant_en) begin
                r_grant        <= w_grant;
                r_last         <= w_grant;
                r_sram_request <= 1'b1;
                r_sram_rw      <= w_sel_rw;
                r_sram_address <= w_sel_address;
                r_sram_wdata   <= w_sel_wdata;
            end

            if (w_capture || w_abort) begin
                r_sram_request <= 1'b0;
            end

            for (int i = 0; i < NPORTS; i++) begin
                if (w_capture && !r_sram_rw && (r_grant == 2'(i))) begin
                    r_rdata[i] <= i_sram_rdata;
                end
            end
        end
    end

    assign o_sram_request = r_sram_request;
    assign o_sram_rw      = r_sram_rw;
    assign o_sram_address = r_sram_address;
    assign o_sram_wdata   = r_sram_wdata;
    assign o_p0_rdata     = r_rdata[0];
    assign o_p1_rdata     = r_rdata[1];
    assign o_p2_rdata     = r_rdata[2];
    assign o_p0_ready     = r_ready[0];
    assign o_p1_ready     = r_ready[1];
    assign o_p2_ready     = r_ready[2];
    assign o_busy         = (r_state != ST_IDLE);
    assign o_error        = r_error;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a latency-programmable SRAM model feeds a
// scoreboard of expected completions that is popped on every ready pulse.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req;
    logic [2:0]  rw;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata0, rdata1, rdata2;
    logic        rdy0, rdy1, rdy2;
    logic        sram_req, sram_rw, sram_ready;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
    logic        busy, error;
    wire  [2:0]  w_rdy = {rdy2, rdy1, rdy0};

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          port;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] exp_rd [3];

    int          sram_cnt;
    int          sram_lat;
    bit          sram_never;
    logic [31:0] key;

    always #5 clk = ~clk;

    sram_arbiter #(.TIMEOUT(63)) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_p0_request   (req[0]),
        .i_p0_rw        (rw[0]),
        .i_p0_address   (addr[0]),
        .i_p0_wdata     (wdata[0]),
        .o_p0_rdata     (rdata0),
        .o_p0_ready     (rdy0),
        .i_p1_request   (req[1]),
        .i_p1_rw        (rw[1]),
        .i_p1_address   (addr[1]),
        .i_p1_wdata     (wdata[1]),
        .o_p1_rdata     (rdata1),
        .o_p1_ready     (rdy1),
        .i_p2_request   (req[2]),
        .i_p2_rw        (rw[2]),
        .i_p2_address   (addr[2]),
        .i_p2_wdata     (wdata[2]),
        .o_p2_rdata     (rdata2),
        .o_p2_ready     (rdy2),
        .o_sram_request (sram_req),
        .o_sram_rw      (sram_rw),
        .o_sram_address (sram_addr),
        .o_sram_wdata   (sram_wdata),
        .i_sram_rdata   (sram_rdata),
        .i_sram_ready   (sram_ready),
        .o_busy         (busy),
        .o_error        (error)
    );

    // SRAM model: ready on the sram_lat-th consecutive request cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        sram_cnt <= 0;
        else if (sram_req) sram_cnt <= sram_cnt + 1;
        else               sram_cnt <= 0;
    end
    assign sram_ready = sram_req && !sram_never && (sram_cnt == sram_lat - 1);
    assign sram_rdata = sram_addr ^ key;

    function automatic logic [31:0] port_rdata(input int p);
        case (p)
            0:       return rdata0;
            1:       return rdata1;
            default: return rdata2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic err);
        exp_t e;
        req[p]   = 1'b1;
        rw[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
        if (!w && !err) exp_rd[p] = a ^ key;
        e.port  = p;
        e.rw    = w;
        e.addr  = a;
        e.wdata = d;
        e.rdata = exp_rd[p];
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int exp_n, input int budget);
        int   n = 0;
        int   bad = 0;
        bit   found = 0;
        exp_t e;
        while (!found && n < budget) begin
            @(negedge clk);
            n++;
            if (w_rdy != 3'b000) begin
                found = 1;
            end else if (sram_req && sb.size() > 0) begin
                if (sram_addr !== sb[0].addr || sram_rw !== sb[0].rw || sram_wdata !== sb[0].wdata)
                    bad++;
            end
        end
        if (!found || sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_done observed=found%0d_sb%0d expected=ready_with_entry", tag, found, sb.size());
            return;
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, 32'(n), 32'(exp_n));
        chk({tag, "_port"}, {29'b0, w_rdy}, 32'(1 << e.port));
        chk({tag, "_rdata"}, port_rdata(e.port), e.rdata);
        chk({tag, "_error"}, {31'b0, error}, {31'b0, e.err});
        chk({tag, "_hold"}, 32'(bad), 32'd0);
        chk({tag, "_gap"}, {31'b0, sram_req}, 32'd0);
        req[e.port] = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
        chk({tag, "_pulse"}, {28'b0, error, w_rdy}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        req = '0;
        rw  = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i]   = '0;
            wdata[i]  = '0;
            exp_rd[i] = '0;
        end
        key        = '0;
        sram_lat   = 6;
        sram_never = 0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_sram_req", {31'b0, sram_req}, 32'd0);
        chk("rst_ready", {29'b0, w_rdy}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_rdata2", rdata2, 32'd0);
        chk("rst_sram_addr", sram_addr, 32'd0);
        chk("rst_sram_wdata", sram_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // P0 read of 0x100 returning 0xDEADBEEF after six request cycles
        key = 32'hDEADBEEF ^ 32'h0000_0100;
        issue(0, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
        @(negedge clk);
        chk("t1_sram_req", {31'b0, sram_req}, 32'd1);
        chk("t1_sram_addr", sram_addr, 32'h0000_0100);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        wait_done("t1", 6, 20);
        chk("t1_value", rdata0, 32'hDEADBEEF);

        // P1 write; requester inputs scrambled mid-BUSY must not reach the SRAM side
        key = 32'h0F0F_0F0F;
        issue(1, 1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0);
        repeat (2) @(negedge clk);
        chk("t2_rw", {31'b0, sram_rw}, 32'd1);
        chk("t2_wdata", sram_wdata, 32'h1234_5678);
        addr[1]  = 32'hFFFF_0000;
        wdata[1] = 32'h0;
        rw[1]    = 1'b0;
        wait_done("t2", 5, 20);
        chk("t2_rdata_kept", rdata1, 32'd0);

        // P1 read with the request withdrawn mid-BUSY
        issue(1, 1'b0, 32'h0000_0080, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        req[1] = 1'b0;
        wait_done("t3", 4, 20);

        // P2 read that the SRAM never answers: abort after 63 BUSY cycles
        sram_never = 1;
        issue(2, 1'b0, 32'h0000_0200, 32'h0, 1'b1);
        wait_done("t4", 64, 100);
        chk("t4_rdata_kept", rdata2, 32'd0);
        sram_never = 0;

        // Ready on the 63rd BUSY cycle coincides with the timeout: completion wins
        sram_lat = 63;
        issue(2, 1'b0, 32'h0000_0300, 32'h0, 1'b0);
        wait_done("t5", 64, 100);
        sram_lat = 6;

        // All three requesters held together, then P0 alone
        issue(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        issue(1, 1'b0, 32'h0000_0014, 32'h0, 1'b0);
        issue(2, 1'b0, 32'h0000_0018, 32'h0, 1'b0);
        wait_done("t6a", 7, 20);
        wait_done("t6b", 7, 20);
        wait_done("t6c", 7, 20);
        issue(0, 1'b0, 32'h0000_001C, 32'h0, 1'b0);
        wait_done("t6d", 7, 20);

        // Reset at the third BUSY cycle
        issue(0, 1'b0, 32'h0000_0044, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t7_pre_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_sram_req", {31'b0, sram_req}, 32'd0);
        chk("t7_busy", {31'b0, busy}, 32'd0);
        chk("t7_rdata0", rdata0, 32'd0);
        sb.delete();
        req = '0;
        for (int i = 0; i < 3; i++) exp_rd[i] = '0;
        repeat (2) @(negedge clk);
        chk("t7_no_ready", {29'b0, w_rdy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t7_no_ready_after", {29'b0, w_rdy}, 32'd0);
        issue(0, 1'b0, 32'h0000_004C, 32'h0, 1'b0);
        issue(1, 1'b0, 32'h0000_0048, 32'h0, 1'b0);
        wait_done("t7a", 7, 20);
        wait_done("t7b", 7, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 63: max BUSY cycles before abort.
REQ-002 SHALL have port i_clock, input, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports i_pN_request, input, 1, requester N (N=0..2) transaction request, held until o_pN_ready.
REQ-005 SHALL have ports i_pN_rw, input, 1, requester N direction: 1 write, 0 read.
REQ-006 SHALL have ports i_pN_address, input, 32, requester N byte address.
REQ-007 SHALL have ports i_pN_wdata, input, 32, requester N write data.
REQ-008 SHALL have ports o_pN_rdata, output, 32, requester N read data, valid while o_pN_ready is high.
REQ-009 SHALL have ports o_pN_ready, output, 1, requester N one-cycle completion pulse.
REQ-010 SHALL have ports o_sram_request / o_sram_rw, output, 1 each, to the SRAM interface.
REQ-011 SHALL have ports o_sram_address / o_sram_wdata, output, 32 each, to the SRAM interface.
REQ-012 SHALL have ports i_sram_rdata, input, 32, and i_sram_ready, input, 1, from the SRAM interface.
REQ-013 SHALL have port o_busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port o_error, output, 1, one-cycle pulse on timeout abort.

Function
REQ-015 SHALL implement the FSM IDLE -> BUSY -> RELEASE -> IDLE.
REQ-016 IDLE: if any i_pN_request is high, the FSM SHALL register the grant, latch that port's rw/address/wdata into o_sram_*, set o_sram_request=1 and go to BUSY; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: search starts at port (last_grant+1) mod 3; last_grant updates at each grant.
REQ-018 o_sram_rw/address/wdata SHALL remain constant from grant until RELEASE; later requester input changes SHALL be ignored.
REQ-019 BUSY: on i_sram_ready=1, the FSM SHALL capture i_sram_rdata into the granted port's o_pN_rdata, clear o_sram_request and go to RELEASE.
REQ-020 RELEASE SHALL last exactly one cycle with o_sram_request=0, so the SRAM interface counter returns to zero; o_pN_ready SHALL be high for the granted port only during this cycle.
REQ-021 A requester SHALL drop i_pN_request on the edge after seeing o_pN_ready; the next IDLE cycle arbitrates on the updated requests.
REQ-022 Latency: request high in IDLE at cycle t gives o_sram_request at t+1; with the SRAM interface ready at its 6th request cycle, o_pN_ready appears at t+7 and the next grant is possible at t+9.
REQ-023 For writes, o_pN_rdata SHALL be left unchanged; o_pN_ready SHALL still pulse.
REQ-024 A 7-bit BUSY cycle counter SHALL clear on entry to BUSY; if it reaches TIMEOUT without i_sram_ready, the FSM SHALL go to RELEASE with o_error=1, pulse o_pN_ready, and leave o_pN_rdata unchanged.
REQ-025 If i_sram_ready and the timeout coincide, completion SHALL win and o_error SHALL stay 0.
REQ-026 A requester dropping i_pN_request mid-BUSY SHALL NOT abort the transaction; it completes and the ready pulse is still issued.
REQ-027 Requests arriving during BUSY or RELEASE SHALL wait; none are lost while held high.

Reset
REQ-028 While i_reset_n=0, all outputs SHALL reset immediately and asynchronously: FSM to IDLE; o_sram_request, o_pN_ready, o_error and o_busy to 0; o_sram_*/o_pN_rdata to 0; last_grant to 2 (port 0 wins first); timeout counter to 0.
REQ-029 Reset during BUSY SHALL drop o_sram_request immediately and SHALL NOT emit o_pN_ready.

Structure
REQ-030 FSM state encodings, NPORTS=3 and the timeout counter width SHALL live in shared package sram_pkg.
REQ-031 Round-robin selection SHALL be one combinational sub-module, rr_select3 (inputs: request[2:0] and last[1:0]; outputs: valid and grant[1:0]).

Verification
REQ-032 P0 read only at 0x100, SRAM model returns 0xDEADBEEF after 6 cycles -> o_p0_rdata=0xDEADBEEF, o_p0_ready at t+7, one-cycle RELEASE gap.
REQ-033 P0, P1 and P2 request together, all held -> grants in order 0,1,2; then P0 again -> 0.
REQ-034 P1 write 0x12345678 to 0x40 -> o_sram_rw=1, o_sram_wdata=0x12345678 held for the whole BUSY period; o_p1_rdata unchanged.
REQ-035 SRAM model never asserts ready, TIMEOUT=63 -> o_error and o_p2_ready pulse together after 63 BUSY cycles; FSM back in IDLE.
REQ-036 i_reset_n dropped at the 3rd BUSY cycle -> o_sram_request=0 immediately, no ready pulse; first grant after reset goes to P0.
